// File: rtl/vga_grid_renderer_if.sv
`default_nettype none
// ============================================================================
// vga_grid_renderer_if : colour, sync and framing outputs of the renderer
// Rev 1.0 - initial release
// ============================================================================
interface vga_grid_renderer_if;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [2:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       frame_start;
  logic       pix_active;

  modport master (
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, pix_active
  );

  modport slave (
    input vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, pix_active
  );
endinterface
`default_nettype wire

// File: rtl/vga_grid_renderer.sv
`default_nettype none
// ============================================================================
// vga_grid_renderer : VGA timing plus a two-stage pipeline drawing a cell grid
//                     with a frog sprite and car sprites (frame-latched).
// Rev 1.0 - initial release
// ============================================================================
module vga_grid_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_LOG2  = 5,
  parameter int NUM_CARS   = 11,
  parameter int SYNC_POL   = 0,
  parameter int GRID_LINES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              frog_col,
  input  logic [3:0]              frog_row,
  input  logic [NUM_CARS*5-1:0]   car_x_bus,
  input  logic [NUM_CARS*4-1:0]   car_y_bus,
  vga_grid_renderer_if.master     vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CCW     = HW - CELL_LOG2;
  localparam int RCW     = VW - CELL_LOG2;

  localparam logic [31:0] H_CELLS  = 32'(H_ACTIVE >> CELL_LOG2);
  localparam logic [31:0] V_CELLS  = 32'(V_ACTIVE >> CELL_LOG2);
  localparam logic        SYNC_ACT = (SYNC_POL != 0);

  localparam logic [8:0] RGB_FROG = 9'o070;
  localparam logic [8:0] RGB_CAR  = 9'o700;
  localparam logic [8:0] RGB_GRID = 9'o111;
  localparam logic [8:0] RGB_SAFE = 9'o030;

  // raster counters
  logic [HW-1:0]         h_count_q, h_count_d;
  logic [VW-1:0]         v_count_q, v_count_d;
  // frame-latched object positions
  logic [4:0]            frog_col_q, frog_col_d;
  logic [3:0]            frog_row_q, frog_row_d;
  logic [NUM_CARS*5-1:0] car_x_q, car_x_d;
  logic [NUM_CARS*4-1:0] car_y_q, car_y_d;
  logic                  frame_start_q, frame_start_d;
  // stage 1
  logic [CCW-1:0]        s1_col_q, s1_col_d;
  logic [RCW-1:0]        s1_row_q, s1_row_d;
  logic                  s1_edge_q, s1_edge_d;
  logic                  s1_vis_q, s1_vis_d;
  logic                  s1_hs_q, s1_hs_d;
  logic                  s1_vs_q, s1_vs_d;
  // stage 2 (pins)
  logic [8:0]            rgb_q, rgb_d;
  logic                  pix_active_q, pix_active_d;
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;

  logic                  latch;
  logic                  frog_hit;
  logic                  car_hit;
  logic                  safe_row;

  always_comb begin
    h_count_d = h_count_q + 1'b1;
    v_count_d = v_count_q;
    if (h_count_q == HW'(H_TOTAL - 1)) begin
      h_count_d = '0;
      if (v_count_q == VW'(V_TOTAL - 1)) begin
        v_count_d = '0;
      end else begin
        v_count_d = v_count_q + 1'b1;
      end
    end

    // Positions are sampled once, at the start of the first blank line.
    latch         = (h_count_q == '0) && (v_count_q == VW'(V_ACTIVE));
    frog_col_d    = latch ? frog_col  : frog_col_q;
    frog_row_d    = latch ? frog_row  : frog_row_q;
    car_x_d       = latch ? car_x_bus : car_x_q;
    car_y_d       = latch ? car_y_bus : car_y_q;
    frame_start_d = latch;

    s1_col_d  = h_count_q[HW-1:CELL_LOG2];
    s1_row_d  = v_count_q[VW-1:CELL_LOG2];
    s1_edge_d = (h_count_q[CELL_LOG2-1:0] == '0) ||
                (v_count_q[CELL_LOG2-1:0] == '0);
    s1_vis_d  = (h_count_q < HW'(H_ACTIVE)) && (v_count_q < VW'(V_ACTIVE));
    s1_hs_d   = (h_count_q >= HW'(H_ACTIVE + H_FP)) &&
                (h_count_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    s1_vs_d   = (v_count_q >= VW'(V_ACTIVE + V_FP)) &&
                (v_count_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
  end

  // Indices are widened to 32 bits so off-screen objects never alias on-screen.
  always_comb begin
    frog_hit = (32'(frog_col_q) < H_CELLS) && (32'(frog_row_q) < V_CELLS) &&
               (32'(frog_col_q) == 32'(s1_col_q)) &&
               (32'(frog_row_q) == 32'(s1_row_q));
    car_hit = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if ((32'(car_x_q[5*i +: 5]) < H_CELLS) &&
          (32'(car_y_q[4*i +: 4]) < V_CELLS) &&
          (32'(car_x_q[5*i +: 5]) == 32'(s1_col_q)) &&
          (32'(car_y_q[4*i +: 4]) == 32'(s1_row_q))) begin
        car_hit = 1'b1;
      end
    end
    safe_row = (s1_row_q == '0) || (32'(s1_row_q) == V_CELLS - 32'd1);

    rgb_d = '0;
    if (s1_vis_q) begin
      if (frog_hit) begin
        rgb_d = RGB_FROG;
      end else if (car_hit) begin
        rgb_d = RGB_CAR;
      end else if ((GRID_LINES != 0) && s1_edge_q) begin
        rgb_d = RGB_GRID;
      end else if (safe_row) begin
        rgb_d = RGB_SAFE;
      end
    end
    pix_active_d = s1_vis_q;
    hs_d         = s1_hs_q ? SYNC_ACT : ~SYNC_ACT;
    vs_d         = s1_vs_q ? SYNC_ACT : ~SYNC_ACT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      frog_col_q    <= '0;
      frog_row_q    <= '0;
      car_x_q       <= '0;
      car_y_q       <= '0;
      frame_start_q <= 1'b0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_edge_q     <= 1'b0;
      s1_vis_q      <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      rgb_q         <= '0;
      pix_active_q  <= 1'b0;
      hs_q          <= ~SYNC_ACT;
      vs_q          <= ~SYNC_ACT;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frog_col_q    <= frog_col_d;
      frog_row_q    <= frog_row_d;
      car_x_q       <= car_x_d;
      car_y_q       <= car_y_d;
      frame_start_q <= frame_start_d;
      s1_col_q      <= s1_col_d;
      s1_row_q      <= s1_row_d;
      s1_edge_q     <= s1_edge_d;
      s1_vis_q      <= s1_vis_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      rgb_q         <= rgb_d;
      pix_active_q  <= pix_active_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign vga.vga_r       = rgb_q[8:6];
  assign vga.vga_g       = rgb_q[5:3];
  assign vga.vga_b       = rgb_q[2:0];
  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.frame_start = frame_start_q;
  assign vga.pix_active  = pix_active_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_renderer.sv
`default_nettype none
// ============================================================================
// tb_vga_grid_renderer : directed checks of timing, sprites, latching, reset
// Rev 1.0 - initial release
// ============================================================================
module tb_vga_grid_renderer;

  // Reduced raster: 80x60 visible, 96x67 total, 4-pixel cells -> 20x15 cells.
  localparam int HT    = 96;
  localparam int VT    = 67;
  localparam int FRAME = HT * VT;

  localparam logic [8:0] GRN = 9'o070;
  localparam logic [8:0] RED = 9'o700;
  localparam logic [8:0] GRD = 9'o111;
  localparam logic [8:0] SAF = 9'o030;
  localparam logic [8:0] BLK = 9'o000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  frog_col;
  logic [3:0]  frog_row;
  logic [54:0] car_x;
  logic [43:0] car_y;
  logic [4:0]  frog2_col;
  logic [3:0]  frog2_row;
  logic [4:0]  car2_x;
  logic [3:0]  car2_y;

  int cyc;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_grid_renderer_if vif ();
  vga_grid_renderer_if vif2 ();

  vga_grid_renderer #(
    .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CELL_LOG2(2), .NUM_CARS(11), .SYNC_POL(0), .GRID_LINES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frog_col(frog_col), .frog_row(frog_row),
    .car_x_bus(car_x), .car_y_bus(car_y),
    .vga(vif)
  );

  // Active-high syncs, single car, 2-pixel cells -> 40x30 cells.
  vga_grid_renderer #(
    .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CELL_LOG2(1), .NUM_CARS(1), .SYNC_POL(1), .GRID_LINES(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .frog_col(frog2_col), .frog_row(frog2_row),
    .car_x_bus(car2_x), .car_y_bus(car2_y),
    .vga(vif2)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic set_all_cars(input logic [4:0] x, input logic [3:0] y);
    for (int i = 0; i < 11; i++) begin
      car_x[5*i +: 5] = x;
      car_y[4*i +: 4] = y;
    end
  endtask

  // Advance to the negedge where the pins show pixel (x,y).
  task automatic wait_pix(input int x, input int y);
    bit hit = 1'b0;
    for (int k = 0; k < FRAME + 8 && !hit; k++) begin
      @(negedge clk);
      if (cyc >= 2 && ((cyc - 2) % FRAME) == (y * HT + x)) hit = 1'b1;
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL wait_pix(%0d,%0d): pixel never reached, required within %0d clocks", x, y, FRAME);
    end
  endtask

  task automatic wait_frame_start();
    bit hit = 1'b0;
    for (int k = 0; k < FRAME + 8 && !hit; k++) begin
      @(negedge clk);
      if (vif.frame_start === 1'b1) hit = 1'b1;
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL wait_frame_start: no pulse seen, required within %0d clocks", FRAME);
    end
  endtask

  task automatic test_reset();
    frog_col = 5'd3; frog_row = 4'd5;
    set_all_cars(5'd31, 4'd15);
    frog2_col = 5'd10; frog2_row = 4'd10;
    car2_x = 5'd31; car2_y = 4'd15;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== BLK) begin
      fails++; $display("FAIL reset_rgb: got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, BLK);
    end
    tests++;
    if ({vif.pix_active, vif.frame_start} !== 2'b00) begin
      fails++; $display("FAIL reset_flags: got %b required 00", {vif.pix_active, vif.frame_start});
    end
    tests++;
    if ({vif.vga_hs, vif.vga_vs, vif2.vga_hs, vif2.vga_vs} !== 4'b1100) begin
      fails++; $display("FAIL reset_syncs: got %b required 1100", {vif.vga_hs, vif.vga_vs, vif2.vga_hs, vif2.vga_vs});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    @(negedge clk);
    tests++;
    if (vif.pix_active !== 1'b0) begin
      fails++; $display("FAIL first_cyc1_pix: got %b required 0", vif.pix_active);
    end
    @(negedge clk);
    tests++;
    if ({vif.pix_active, vif.vga_r, vif.vga_g, vif.vga_b} !== {1'b1, GRN}) begin
      fails++; $display("FAIL first_pixel: got %o required %o", {vif.pix_active, vif.vga_r, vif.vga_g, vif.vga_b}, {1'b1, GRN});
    end
    tests++;
    if ({vif2.vga_r, vif2.vga_g, vif2.vga_b} !== GRN) begin
      fails++; $display("FAIL first_pixel_dut2: got %o required %o", {vif2.vga_r, vif2.vga_g, vif2.vga_b}, GRN);
    end
    wait_pix(4, 5);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== GRD) begin
      fails++; $display("FAIL first_grid(4,5): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, GRD);
    end
    wait_pix(5, 5);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== BLK) begin
      fails++; $display("FAIL first_black(5,5): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, BLK);
    end
  endtask

  task automatic test_timing();
    int hs_lo = 0, vs_lo = 0, fs_n = 0, fs_at = -1, pix_n = 0, hs2_hi = 0;
    int hs_first = -1, vs_first = -1;
    bit ok = 1'b0;
    for (int k = 0; k < 3 * FRAME && !ok; k++) begin
      @(negedge clk);
      if (cyc == FRAME + 2) ok = 1'b1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL timing_start: frame 1 not reached, cyc=%0d", cyc);
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      if (vif.vga_hs === 1'b0) begin hs_lo++; if (hs_first < 0) hs_first = i; end
      if (vif.vga_vs === 1'b0) begin vs_lo++; if (vs_first < 0) vs_first = i; end
      if (vif.frame_start === 1'b1) begin fs_n++; fs_at = i; end
      if (vif.pix_active === 1'b1) pix_n++;
      if (vif2.vga_hs === 1'b1) hs2_hi++;
      @(negedge clk);
    end
    tests++;
    if (hs_lo != 8 * VT) begin fails++; $display("FAIL hs_low_clocks: got %0d required %0d", hs_lo, 8 * VT); end
    tests++;
    if (hs_first != 84) begin fails++; $display("FAIL hs_first: got %0d required 84", hs_first); end
    tests++;
    if (vs_lo != 2 * HT) begin fails++; $display("FAIL vs_low_clocks: got %0d required %0d", vs_lo, 2 * HT); end
    tests++;
    if (vs_first != 62 * HT) begin fails++; $display("FAIL vs_first: got %0d required %0d", vs_first, 62 * HT); end
    tests++;
    if (fs_n != 1 || fs_at != 60 * HT - 1) begin
      fails++; $display("FAIL frame_start: got %0d pulses at %0d required 1 at %0d", fs_n, fs_at, 60 * HT - 1);
    end
    tests++;
    if (pix_n != 80 * 60) begin fails++; $display("FAIL pix_active_count: got %0d required %0d", pix_n, 80 * 60); end
    tests++;
    if (hs2_hi != 8 * VT) begin fails++; $display("FAIL hs_high_pol1: got %0d required %0d", hs2_hi, 8 * VT); end
  endtask

  task automatic test_frog();
    int xs [10];
    int ys [10];
    logic [9:0] es [10];
    logic [9:0] got;
    xs = '{1, 11, 12, 16, 15, 13, 17, 1, 79, 80};
    ys = '{1, 20, 20, 21, 23, 24, 25, 57, 59, 59};
    es = '{{1'b1, SAF}, {1'b1, GRD}, {1'b1, GRN}, {1'b1, GRD}, {1'b1, GRN},
           {1'b1, GRD}, {1'b1, BLK}, {1'b1, SAF}, {1'b1, SAF}, {1'b0, BLK}};
    wait_frame_start();
    for (int i = 0; i < 10; i++) begin
      wait_pix(xs[i], ys[i]);
      got = {vif.pix_active, vif.vga_r, vif.vga_g, vif.vga_b};
      tests++;
      if (got !== es[i]) begin
        fails++; $display("FAIL frog_scene(%0d,%0d): got %o required %o", xs[i], ys[i], got, es[i]);
      end
    end
  endtask

  task automatic test_overlap_midframe();
    wait_frame_start();
    set_all_cars(5'd31, 4'd15);
    car_x[4:0] = 5'd4; car_y[3:0] = 4'd4;
    frog_col = 5'd4; frog_row = 4'd4;
    wait_pix(17, 17);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== BLK) begin
      fails++; $display("FAIL overlap_not_yet(17,17): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, BLK);
    end
    wait_pix(13, 21);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== GRN) begin
      fails++; $display("FAIL old_frog_kept(13,21): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, GRN);
    end
    wait_frame_start();
    wait_pix(17, 17);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== GRN) begin
      fails++; $display("FAIL frog_on_car(17,17): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, GRN);
    end
    frog_col = 5'd5;
    wait_pix(21, 17);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== BLK) begin
      fails++; $display("FAIL move_midframe(21,17): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, BLK);
    end
    wait_pix(13, 21);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== BLK) begin
      fails++; $display("FAIL old_frog_gone(13,21): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, BLK);
    end
    wait_frame_start();
    wait_pix(17, 17);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== RED) begin
      fails++; $display("FAIL car_alone(17,17): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, RED);
    end
    wait_pix(21, 17);
    tests++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== GRN) begin
      fails++; $display("FAIL frog_moved(21,17): got %o required %o", {vif.vga_r, vif.vga_g, vif.vga_b}, GRN);
    end
  endtask

  task automatic test_car10();
    int xs [5];
    int ys [5];
    logic [8:0] es [5];
    logic [8:0] got;
    xs = '{17, 76, 72, 75, 79};
    ys = '{17, 56, 57, 57, 59};
    es = '{BLK, RED, GRD, SAF, RED};
    frog_col = 5'd31; frog_row = 4'd15;
    set_all_cars(5'd31, 4'd15);
    car_x[54:50] = 5'd19; car_y[43:40] = 4'd14;
    wait_frame_start();
    for (int i = 0; i < 5; i++) begin
      wait_pix(xs[i], ys[i]);
      got = {vif.vga_r, vif.vga_g, vif.vga_b};
      tests++;
      if (got !== es[i]) begin
        fails++; $display("FAIL car10_scene(%0d,%0d): got %o required %o", xs[i], ys[i], got, es[i]);
      end
    end
  endtask

  task automatic test_polarity_small_cells();
    int xs [6];
    int ys [6];
    logic [8:0] es [6];
    logic [8:0] got;
    xs = '{20, 62, 64, 61, 63, 1};
    ys = '{20, 30, 30, 31, 31, 59};
    es = '{GRN, RED, GRD, BLK, RED, SAF};
    wait_frame_start();
    for (int i = 0; i < 6; i++) begin
      wait_pix(xs[i], ys[i]);
      got = {vif2.vga_r, vif2.vga_g, vif2.vga_b};
      tests++;
      if (got !== es[i]) begin
        fails++; $display("FAIL pol1_scene(%0d,%0d): got %o required %o", xs[i], ys[i], got, es[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int hs_first = -1, hs2_first = -1;
    wait_pix(28, 20);
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) #1;
      else repeat (5) @(negedge clk);
      tests++;
      if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.pix_active, vif.frame_start} !== 11'b0) begin
        fails++; $display("FAIL rst_mid_outputs[%0d]: got %b required 0", r,
                          {vif.vga_r, vif.vga_g, vif.vga_b, vif.pix_active, vif.frame_start});
      end
      tests++;
      if ({vif.vga_hs, vif.vga_vs, vif2.vga_hs, vif2.vga_vs} !== 4'b1100) begin
        fails++; $display("FAIL rst_mid_syncs[%0d]: got %b required 1100", r,
                          {vif.vga_hs, vif.vga_vs, vif2.vga_hs, vif2.vga_vs});
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cyc == 1) begin
        tests++;
        if (vif.pix_active !== 1'b0) begin fails++; $display("FAIL rst_mid_cyc1_pix: got %b required 0", vif.pix_active); end
      end
      if (cyc == 2) begin
        tests++;
        if (vif.pix_active !== 1'b1) begin fails++; $display("FAIL rst_mid_cyc2_pix: got %b required 1", vif.pix_active); end
      end
      if (hs_first < 0 && vif.vga_hs === 1'b0) hs_first = cyc;
      if (hs2_first < 0 && vif2.vga_hs === 1'b1) hs2_first = cyc;
    end
    tests++;
    if (hs_first != 86) begin fails++; $display("FAIL rst_mid_first_hs: got %0d required 86", hs_first); end
    tests++;
    if (hs2_first != 86) begin fails++; $display("FAIL rst_mid_first_hs_pol1: got %0d required 86", hs2_first); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_timing();
    test_frog();
    test_overlap_midframe();
    test_car10();
    test_polarity_small_cells();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
